lsu_issue_dispatch: RTL and testbench

LSU_ISSUE_DISPATCH -- requirements
Module: lsu_issue_dispatch

---
 rtl/lsu_issue_dispatch.sv | 125 ++++++++++++
 tb/tb_lsu_issue_dispatch.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_issue_dispatch.sv
// LSU issue dispatch: pops the head of the LSU request buffer into a single hold slot
// and offers it to the load or store unit, throttling loads by an outstanding-load budget.
module lsu_issue_dispatch #(
   parameter int unsigned TRANS_ID_W = 3,
   parameter int unsigned PAYLOAD_W  = 64,
   parameter int unsigned MAX_LD_OUT = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flush_i,
   input  logic                  req_valid_i,
   input  logic                  req_is_store_i,
   input  logic [TRANS_ID_W-1:0] req_trans_id_i,
   input  logic [PAYLOAD_W-1:0]  req_payload_i,
   output logic                  pop_ld_o,
   output logic                  pop_st_o,
   output logic                  ld_valid_o,
   input  logic                  ld_ready_i,
   output logic                  st_valid_o,
   input  logic                  st_ready_i,
   output logic [TRANS_ID_W-1:0] issue_trans_id_o,
   output logic [PAYLOAD_W-1:0]  issue_payload_o,
   input  logic                  ld_done_i,
   output logic [3:0]            ld_outstanding_o,
   output logic                  idle_o
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LD_OUT);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HOLD_LD = 2'd1,
      HOLD_ST = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [TRANS_ID_W-1:0] id_q, id_d;
   logic [PAYLOAD_W-1:0]  payload_q, payload_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_eff;
   logic                  idle_q;
   logic                  ld_hs, st_hs, slot_free, capture;

   assign ld_hs     = (state_q == HOLD_LD) && ld_ready_i;
   assign st_hs     = (state_q == HOLD_ST) && st_ready_i;
   assign slot_free = (state_q == IDLE) || ld_hs || st_hs;

   // Count as it will stand after this cycle's handshake/completion, saturating both ways
   always_comb begin
      cnt_eff = cnt_q;
      if (ld_hs && !ld_done_i) begin
         if (cnt_q != CNT_MAX) cnt_eff = cnt_q + CNT_W'(1);
      end else if (!ld_hs && ld_done_i) begin
         if (cnt_q != '0) cnt_eff = cnt_q - CNT_W'(1);
      end
   end

   assign capture = slot_free && req_valid_i && !flush_i &&
                    (req_is_store_i || (cnt_eff < CNT_MAX));

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic: flush wins, then capture, then release on handshake
   always_comb begin
      state_d = state_q;
      if (flush_i) begin
         state_d = IDLE;
      end else if (capture) begin
         state_d = req_is_store_i ? HOLD_ST : HOLD_LD;
      end else if (ld_hs || st_hs) begin
         state_d = IDLE;
      end
   end

   // FSM outputs
   always_comb begin
      ld_valid_o = 1'b0;
      st_valid_o = 1'b0;
      pop_ld_o   = 1'b0;
      pop_st_o   = 1'b0;
      ld_valid_o = (state_q == HOLD_LD);
      st_valid_o = (state_q == HOLD_ST);
      pop_ld_o   = capture && !req_is_store_i;
      pop_st_o   = capture && req_is_store_i;
   end

   // Hold register and counter next values
   always_comb begin
      id_d      = id_q;
      payload_d = payload_q;
      cnt_d     = cnt_eff;
      if (flush_i) begin
         id_d      = '0;
         payload_d = '0;
         cnt_d     = '0;
      end else if (capture) begin
         id_d      = req_trans_id_i;
         payload_d = req_payload_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         id_q      <= '0;
         payload_q <= '0;
         cnt_q     <= '0;
         idle_q    <= 1'b1;
      end else begin
         id_q      <= id_d;
         payload_q <= payload_d;
         cnt_q     <= cnt_d;
         idle_q    <= (state_d == IDLE) && (cnt_d == '0);
      end
   end

   assign issue_trans_id_o = id_q;
   assign issue_payload_o  = payload_q;
   assign ld_outstanding_o = cnt_q;
   assign idle_o           = idle_q;

endmodule

// File: tb/tb_lsu_issue_dispatch.sv
// Bench for lsu_issue_dispatch: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a transaction-level model.
module tb_lsu_issue_dispatch;

   localparam int unsigned TW  = 3;
   localparam int unsigned PW  = 64;
   localparam int          MAX = 4;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          flush_i, req_valid_i, req_is_store_i;
   logic [TW-1:0] req_trans_id_i;
   logic [PW-1:0] req_payload_i;
   logic          pop_ld_o, pop_st_o, ld_valid_o, ld_ready_i, st_valid_o, st_ready_i;
   logic [TW-1:0] issue_trans_id_o;
   logic [PW-1:0] issue_payload_o;
   logic          ld_done_i;
   logic [3:0]    ld_outstanding_o;
   logic          idle_o;

   int checks = 0;
   int errors = 0;

   // Model: one slot that may hold a request, plus an integer load budget
   bit            m_held;
   bit            m_store;
   logic [TW-1:0] m_id;
   logic [PW-1:0] m_pl;
   int            m_cnt;

   lsu_issue_dispatch #(.TRANS_ID_W(TW), .PAYLOAD_W(PW), .MAX_LD_OUT(MAX)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
      .req_valid_i(req_valid_i), .req_is_store_i(req_is_store_i),
      .req_trans_id_i(req_trans_id_i), .req_payload_i(req_payload_i),
      .pop_ld_o(pop_ld_o), .pop_st_o(pop_st_o),
      .ld_valid_o(ld_valid_o), .ld_ready_i(ld_ready_i),
      .st_valid_o(st_valid_o), .st_ready_i(st_ready_i),
      .issue_trans_id_o(issue_trans_id_o), .issue_payload_o(issue_payload_o),
      .ld_done_i(ld_done_i), .ld_outstanding_o(ld_outstanding_o), .idle_o(idle_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_held = 0; m_store = 0; m_id = '0; m_pl = '0; m_cnt = 0;
   endtask

   task automatic set_req(input bit v, input bit st, input logic [TW-1:0] id);
      req_valid_i    = v;
      req_is_store_i = st;
      req_trans_id_i = id;
      req_payload_i  = {$urandom, $urandom};
   endtask

   // Inputs are already set (just after a negedge): check all outputs, advance model, move to next negedge
   task automatic step();
      bit hs, hs_ld, cap;
      int eff;
      #1;
      hs    = m_held && (m_store ? st_ready_i : ld_ready_i);
      hs_ld = hs && !m_store;
      eff   = m_cnt + int'(hs_ld) - int'(ld_done_i);
      if (eff < 0)   eff = 0;
      if (eff > MAX) eff = MAX;
      cap = (!m_held || hs) && req_valid_i && !flush_i && (req_is_store_i || eff < MAX);

      chk("ld_valid", 64'(ld_valid_o), 64'(m_held && !m_store));
      chk("st_valid", 64'(st_valid_o), 64'(m_held && m_store));
      chk("pop_ld", 64'(pop_ld_o), 64'(cap && !req_is_store_i));
      chk("pop_st", 64'(pop_st_o), 64'(cap && req_is_store_i));
      chk("issue_id", 64'(issue_trans_id_o), 64'(m_id));
      chk("issue_payload", issue_payload_o, m_pl);
      chk("outstanding", 64'(ld_outstanding_o), 64'(m_cnt));
      chk("idle", 64'(idle_o), 64'(!m_held && m_cnt == 0));

      if (flush_i) begin
         model_reset();
      end else begin
         m_cnt = eff;
         if (cap) begin
            m_held = 1; m_store = req_is_store_i; m_id = req_trans_id_i; m_pl = req_payload_i;
         end else if (hs) begin
            m_held = 0;
         end
      end
      @(negedge clk_i);
   endtask

   task automatic quiet();
      flush_i = 0; ld_ready_i = 0; st_ready_i = 0; ld_done_i = 0;
      set_req(0, 0, '0);
   endtask

   initial begin
      rst_ni = 0;
      quiet();
      model_reset();
      @(negedge clk_i);
      #1;
      chk("rst_ld_valid", 64'(ld_valid_o), 64'd0);
      chk("rst_st_valid", 64'(st_valid_o), 64'd0);
      chk("rst_outstanding", 64'(ld_outstanding_o), 64'd0);
      chk("rst_idle", 64'(idle_o), 64'd1);
      chk("rst_payload", issue_payload_o, 64'd0);
      @(negedge clk_i);
      rst_ni = 1;

      // Load capture, stall, then handshake
      set_req(1, 0, 3'd5);
      #1 chk("lc_pop_ld", 64'(pop_ld_o), 64'd1);
      step();
      set_req(0, 0, '0);
      #1 chk("lc_ld_valid", 64'(ld_valid_o), 64'd1);
      chk("lc_pop_ld_once", 64'(pop_ld_o), 64'd0);
      for (int i = 0; i < 3; i++) begin
         #1 chk("lc_stall_id", 64'(issue_trans_id_o), 64'd5);
         step();
      end
      ld_ready_i = 1;
      step();
      ld_ready_i = 0;
      #1 chk("lc_outstanding", 64'(ld_outstanding_o), 64'd1);
      ld_done_i = 1;
      step();
      ld_done_i = 0;

      // Four streaming stores with no bubble
      st_ready_i = 1;
      for (int i = 0; i < 5; i++) begin
         set_req(i < 4, 1, TW'(i));
         #1;
         if (i < 4) chk("stream_pop_st", 64'(pop_st_o), 64'd1);
         if (i > 0) chk("stream_st_valid", 64'(st_valid_o), 64'd1);
         step();
      end
      quiet();

      // Load limit: fifth load waits for a completion
      ld_ready_i = 1;
      for (int i = 0; i < 4; i++) begin
         set_req(1, 0, TW'(i));
         step();
      end
      set_req(1, 0, 3'd4);
      #1 chk("lim_no_pop_hs", 64'(pop_ld_o), 64'd0);
      step();
      #1 chk("lim_no_pop", 64'(pop_ld_o), 64'd0);
      chk("lim_count4", 64'(ld_outstanding_o), 64'd4);
      step();
      ld_done_i = 1;
      #1 chk("lim_pop_on_done", 64'(pop_ld_o), 64'd1);
      step();
      ld_done_i = 0;
      set_req(0, 0, '0);
      step();
      #1 chk("lim_count_after", 64'(ld_outstanding_o), 64'd4);

      // Store at full load budget is not blocked
      ld_ready_i = 0; st_ready_i = 1;
      set_req(1, 1, 3'd6);
      #1 chk("mix_pop_st", 64'(pop_st_o), 64'd1);
      step();
      set_req(0, 0, '0);
      #1 chk("mix_st_valid", 64'(st_valid_o), 64'd1);
      step();
      st_ready_i = 0;

      // Flush with a held load and count 2
      ld_done_i = 1;
      step();
      step();
      ld_done_i = 0;
      set_req(1, 0, 3'd2);
      step();
      #1 chk("fl_count2", 64'(ld_outstanding_o), 64'd2);
      flush_i = 1; ld_ready_i = 1;
      set_req(1, 0, 3'd3);
      #1 chk("fl_no_pop", 64'(pop_ld_o | pop_st_o), 64'd0);
      step();
      quiet();
      #1 chk("fl_idle_state", 64'(ld_valid_o), 64'd0);
      chk("fl_count0", 64'(ld_outstanding_o), 64'd0);

      // Done at zero, then handshake plus done at count 3
      ld_done_i = 1;
      step();
      ld_done_i = 0;
      #1 chk("b_zero", 64'(ld_outstanding_o), 64'd0);
      ld_ready_i = 1;
      for (int i = 0; i < 4; i++) begin
         set_req(1, 0, TW'(i));
         step();
      end
      set_req(0, 0, '0);
      #1 chk("b_count3", 64'(ld_outstanding_o), 64'd3);
      ld_done_i = 1;
      step();
      #1 chk("b_still3", 64'(ld_outstanding_o), 64'd3);
      quiet();

      // Randomized traffic, with occasional flush and mid-flight reset
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 299) == 0) begin
            quiet();
            rst_ni = 0;
            #1;
            model_reset();
            chk("rnd_rst_valid", 64'(ld_valid_o | st_valid_o), 64'd0);
            chk("rnd_rst_count", 64'(ld_outstanding_o), 64'd0);
            chk("rnd_rst_idle", 64'(idle_o), 64'd1);
            @(negedge clk_i);
            rst_ni = 1;
         end
         set_req($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, TW'($urandom));
         ld_ready_i = $urandom_range(0, 9) < 6;
         st_ready_i = $urandom_range(0, 9) < 6;
         ld_done_i  = $urandom_range(0, 9) < 3;
         flush_i    = $urandom_range(0, 49) == 0;
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
